// File: rtl/mp64_mbox_agent.sv
// mp64_mbox_agent
//   Per-core mailbox agent. Sends 64-bit messages to another core by writing
//   the eight data bytes and then the target ID to the mailbox MMIO window.
//   Receives messages when the mailbox raises the IPI line: reads STATUS,
//   picks the lowest pending source, reads the eight data bytes, ACKs the
//   source, and presents the message on a one-deep rx buffer.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   tx_valid/tx_ready           outbound request handshake
//   tx_target, tx_data          destination core and payload
//   tx_done                     1-cycle pulse when SEND completes
//   ipi_in                      IPI line from the mailbox
//   rx_valid/rx_ready           buffered message handshake
//   rx_src, rx_data             source core and payload of buffered message
//   rx_spurious                 1-cycle pulse when STATUS had no pending source
//   m_req/m_addr/m_wdata/m_wen  registered MMIO request, held until m_ack
//   m_rdata, m_ack              MMIO read byte and completion
module mp64_mbox_agent #(
    parameter int          NUM_CORES    = 4,
    parameter int          CORE_ID_BITS = 2,
    parameter logic [11:0] MBOX_BASE    = 12'h500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    input  logic [CORE_ID_BITS-1:0] tx_target,
    input  logic [63:0]             tx_data,
    output logic                    tx_done,
    input  logic                    ipi_in,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic [CORE_ID_BITS-1:0] rx_src,
    output logic [63:0]             rx_data,
    output logic                    rx_spurious,
    output logic                    m_req,
    output logic [11:0]             m_addr,
    output logic [7:0]              m_wdata,
    output logic                    m_wen,
    input  logic [7:0]              m_rdata,
    input  logic                    m_ack
);

    // Offsets of the control registers inside the mailbox window
    // (MBOX_STATUS, MBOX_SEND, MBOX_ACK from mp64_defs.vh).
    localparam logic [11:0] MBOX_STATUS_OFS = 12'h008;
    localparam logic [11:0] MBOX_SEND_OFS   = 12'h009;
    localparam logic [11:0] MBOX_ACK_OFS    = 12'h00A;

    typedef enum logic [2:0] {
        IDLE,
        TX_DATA,
        TX_SEND,
        RX_STAT,
        RX_DATA,
        RX_ACK
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              idx_q, idx_d, nxt_idx;
    logic [CORE_ID_BITS-1:0] tgt_q, tgt_d;
    logic [CORE_ID_BITS-1:0] src_q, src_d;
    logic [63:0]             tx_buf_q, tx_buf_d;
    logic [63:0]             shadow_q, shadow_d;
    logic                    armed_q;

    logic                    m_req_d, m_wen_d;
    logic [11:0]             m_addr_d;
    logic [7:0]              m_wdata_d;
    logic                    tx_done_d, rx_spurious_d, rx_valid_d;
    logic [63:0]             rx_data_d;
    logic [CORE_ID_BITS-1:0] rx_src_d;

    logic                    op_done;
    logic                    ipi_take;

    // Lowest pending source wins.
    function automatic logic [CORE_ID_BITS-1:0] lowest_set(input logic [NUM_CORES-1:0] v);
        lowest_set = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (v[i]) lowest_set = CORE_ID_BITS'(i);
    endfunction

    assign op_done  = m_req && m_ack;
    // armed_q keeps the block quiet for the first edge after reset release.
    assign ipi_take = (state_q == IDLE) && armed_q && ipi_in && !rx_valid;
    assign tx_ready = (state_q == IDLE) && armed_q && !(ipi_in && !rx_valid);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        tgt_d         = tgt_q;
        src_d         = src_q;
        tx_buf_d      = tx_buf_q;
        shadow_d      = shadow_q;
        m_req_d       = m_req;
        m_addr_d      = m_addr;
        m_wdata_d     = m_wdata;
        m_wen_d       = m_wen;
        tx_done_d     = 1'b0;
        rx_spurious_d = 1'b0;
        rx_valid_d    = rx_valid && !rx_ready;
        rx_data_d     = rx_data;
        rx_src_d      = rx_src;
        nxt_idx       = idx_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (ipi_take) begin
                    state_d   = RX_STAT;
                    m_req_d   = 1'b1;
                    m_wen_d   = 1'b0;
                    m_addr_d  = MBOX_BASE + MBOX_STATUS_OFS;
                    m_wdata_d = 8'h00;
                end else if (tx_valid && tx_ready) begin
                    state_d   = TX_DATA;
                    tgt_d     = tx_target;
                    tx_buf_d  = tx_data;
                    idx_d     = 3'd0;
                    m_req_d   = 1'b1;
                    m_wen_d   = 1'b1;
                    m_addr_d  = MBOX_BASE;
                    m_wdata_d = tx_data[7:0];
                end
            end

            TX_DATA: begin
                if (op_done) begin
                    if (idx_q == 3'd7) begin
                        state_d   = TX_SEND;
                        m_addr_d  = MBOX_BASE + MBOX_SEND_OFS;
                        m_wdata_d = 8'(tgt_q);
                    end else begin
                        idx_d     = nxt_idx;
                        m_addr_d  = MBOX_BASE + {9'd0, nxt_idx};
                        m_wdata_d = tx_buf_q[{nxt_idx, 3'b000} +: 8];
                    end
                end
            end

            TX_SEND: begin
                if (op_done) begin
                    state_d   = IDLE;
                    m_req_d   = 1'b0;
                    m_wen_d   = 1'b0;
                    tx_done_d = 1'b1;
                end
            end

            RX_STAT: begin
                if (op_done) begin
                    if (m_rdata[NUM_CORES-1:0] == '0) begin
                        state_d       = IDLE;
                        m_req_d       = 1'b0;
                        rx_spurious_d = 1'b1;
                    end else begin
                        state_d  = RX_DATA;
                        src_d    = lowest_set(m_rdata[NUM_CORES-1:0]);
                        idx_d    = 3'd0;
                        m_addr_d = MBOX_BASE;
                    end
                end
            end

            RX_DATA: begin
                if (op_done) begin
                    shadow_d[{idx_q, 3'b000} +: 8] = m_rdata;
                    if (idx_q == 3'd7) begin
                        state_d   = RX_ACK;
                        m_wen_d   = 1'b1;
                        m_addr_d  = MBOX_BASE + MBOX_ACK_OFS;
                        m_wdata_d = 8'(src_q);
                    end else begin
                        idx_d    = nxt_idx;
                        m_addr_d = MBOX_BASE + {9'd0, nxt_idx};
                    end
                end
            end

            RX_ACK: begin
                if (op_done) begin
                    state_d    = IDLE;
                    m_req_d    = 1'b0;
                    m_wen_d    = 1'b0;
                    // A same-cycle consumer handshake is overridden by the new message.
                    rx_valid_d = 1'b1;
                    rx_data_d  = shadow_q;
                    rx_src_d   = src_q;
                end
            end

            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tgt_q       <= '0;
            src_q       <= '0;
            tx_buf_q    <= '0;
            shadow_q    <= '0;
            armed_q     <= 1'b0;
            m_req       <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_wen       <= 1'b0;
            tx_done     <= 1'b0;
            rx_spurious <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            rx_src      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tgt_q       <= tgt_d;
            src_q       <= src_d;
            tx_buf_q    <= tx_buf_d;
            shadow_q    <= shadow_d;
            armed_q     <= 1'b1;
            m_req       <= m_req_d;
            m_addr      <= m_addr_d;
            m_wdata     <= m_wdata_d;
            m_wen       <= m_wen_d;
            tx_done     <= tx_done_d;
            rx_spurious <= rx_spurious_d;
            rx_valid    <= rx_valid_d;
            rx_data     <= rx_data_d;
            rx_src      <= rx_src_d;
        end
    end

endmodule

// File: doc/mp64_mbox_agent.md
MP64_MBOX_AGENT -- requirements
Module: mp64_mbox_agent

Interface
REQ-001 SHALL have parameters: NUM_CORES, default 4, number of cores; CORE_ID_BITS, default 2, core-ID width; MBOX_BASE, default 12'h500, mailbox MMIO base.
REQ-002 SHALL have the following ports, with clock and reset first:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- tx_valid  in  1  outbound message request.
- tx_ready  out  1  agent accepts the request this cycle.
- tx_target  in  CORE_ID_BITS  destination core.
- tx_data  in  64  outbound payload.
- tx_done  out  1  1-cycle pulse when SEND completes.
- ipi_in  in  1  IPI line from the mailbox for this core.
- rx_valid  out  1  received message buffered.
- rx_ready  in  1  consumer takes the message.
- rx_src  out  CORE_ID_BITS  source core of the buffered message.
- rx_data  out  64  buffered payload.
- rx_spurious  out  1  1-cycle pulse when an IPI is taken but STATUS reads 0.
- m_req  out  1  MMIO request.
- m_addr  out  12  MMIO offset.
- m_wdata  out  8  write byte.
- m_wen  out  1  1 = write, 0 = read.
- m_rdata  in  8  read byte.
- m_ack  in  1  op completes this cycle.
REQ-003 Register offsets SHALL be taken from mp64_defs.vh: data bytes 0..7 at MBOX_BASE+0..7 (byte k = bits 8k+7:8k); MBOX_STATUS, MBOX_SEND and MBOX_ACK at MBOX_BASE plus the respective define.

Function
REQ-004 Bus op rules:
- m_req, m_addr, m_wdata and m_wen SHALL be registered and stay stable until the cycle with m_req&&m_ack; that cycle completes the op.
- The next op MAY start the following cycle, so back-to-back ops are allowed.
- Read data SHALL be sampled from m_rdata in the completing cycle.
REQ-005 FSM states SHALL be: IDLE, TX_DATA, TX_SEND, RX_STAT, RX_DATA, RX_ACK.
REQ-006 tx_ready SHALL be 1 only when the state is IDLE and not (ipi_in && !rx_valid); incoming IPIs have priority over transmit.
REQ-007 On tx_valid&&tx_ready the agent SHALL latch tx_target and tx_data and enter TX_DATA with byte index 0.
REQ-008 TX_DATA SHALL write bytes 0..7 in ascending order, one per op, then go to TX_SEND.
REQ-009 TX_SEND SHALL write {zero-pad, target} to MBOX_SEND, pulse tx_done in the cycle after the op completes, and return to IDLE.
REQ-010 With m_ack tied high, acceptance at cycle T SHALL give ops at T+1..T+9 and tx_done at T+10, with tx_ready allowed high at T+10.
REQ-011 In IDLE with ipi_in=1 and rx_valid=0 the agent SHALL enter RX_STAT and read MBOX_STATUS.
REQ-012 If STATUS[NUM_CORES-1:0]==0 the agent SHALL pulse rx_spurious and return to IDLE; otherwise it SHALL select src = index of the lowest set bit.
REQ-013 RX_DATA SHALL read bytes 0..7 in ascending order into a shadow register.
REQ-014 RX_ACK SHALL write {zero-pad, src} to MBOX_ACK; on completion the shadow SHALL be copied to rx_data/rx_src, rx_valid set to 1, and the FSM returned to IDLE.
REQ-015 rx_valid SHALL hold with rx_data and rx_src stable until rx_valid&&rx_ready; it SHALL clear the cycle after that handshake.
REQ-016 While rx_valid=1, ipi_in SHALL be ignored (one-deep buffer, back-pressure), and transmit SHALL remain permitted.
REQ-017 A handshake and a new RX_ACK completion in the same cycle SHALL load the new message and keep rx_valid=1.
REQ-018 tx_valid SHALL be ignored in every non-IDLE state; an in-progress sequence SHALL never be interrupted by ipi_in or tx_valid.
REQ-019 tx_target equal to the agent's own core ID SHALL be sent normally, with no special case.
REQ-020 ipi_in still high after RX_ACK (other sources pending) SHALL start a new RX sequence once rx_valid clears.

Reset
REQ-021 While rst_n=0 the block SHALL hold: state IDLE; m_req, m_wen, m_addr, m_wdata = 0; tx_done, rx_valid, rx_spurious = 0; rx_data, rx_src and the shadow = 0.
REQ-022 Reset asserted mid-sequence SHALL abort it immediately, with m_req falling asynchronously; no partial message SHALL appear on rx_*.
REQ-023 After rst_n deasserts, the first op SHALL start no earlier than the second rising clk edge.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- TX: m_ack=1, tx_target=2, tx_data=64'h1122334455667788 -> writes 0x500..0x507 = 88,77,66,55,44,33,22,11, then SEND with wdata=0x02; tx_done at T+10.
- RX: ipi_in=1, STATUS=0x0A, data bytes 0xA0..0xA7 -> src=1, ACK wdata=0x01, rx_data=64'hA7A6A5A4A3A2A1A0, rx_valid held until rx_ready.
- Spurious: ipi_in=1, STATUS=0x00 -> one rx_spurious pulse, no data reads, return to IDLE.
- Priority and back-pressure: tx_valid and ipi_in rise together -> RX runs first; with rx_valid=1 and ipi_in=1 -> TX proceeds and no STATUS read occurs.
- Wait states: m_ack low 3 cycles per op -> address and data stable throughout, ops never skipped or duplicated.
- Reset at the 4th TX data write -> m_req=0 immediately, tx_done never pulses, tx_ready=1 after reset.
